// File: rtl/ma_stage.sv
// Memory-access stage: captures the execute bundle, runs load/store against data memory, and emits a registered writeback pulse.
// Latency: non-memory 1 cycle, memory 2+ cycles. Backpressure: in_ready is high only in IDLE, so upstream holds while an access is pending.
module ma_stage #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       pc,
  input  logic [31:0]       aluResult,
  input  logic [31:0]       op2,
  input  logic [4:0]        rd,
  input  logic              isLd,
  input  logic              isSt,
  input  logic              isWb,
  input  logic              isCall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_result,
  output logic              mem_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t           state, nextState;
  logic [CNT_W-1:0] waitCnt, nextWaitCnt;

  logic              memReq, nextMemReq;
  logic              memWe, nextMemWe;
  logic [ADDR_W-1:0] memAddr, nextMemAddr;
  logic [31:0]       memWdata, nextMemWdata;

  // Control/result of the in-flight access, needed when the ack or abort arrives.
  logic        pendWb, nextPendWb;
  logic [4:0]  pendRd, nextPendRd;
  logic [31:0] pendResult, nextPendResult;

  logic        wbValid, nextWbValid;
  logic        wbEn, nextWbEn;
  logic [4:0]  wbRd, nextWbRd;
  logic [31:0] wbResult, nextWbResult;
  logic        memErr, nextMemErr;

  logic isMem;
  logic misaligned;

  assign isMem      = isLd | isSt;
  assign misaligned = (aluResult[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      waitCnt    <= '0;
      memReq     <= 1'b0;
      memWe      <= 1'b0;
      memAddr    <= '0;
      memWdata   <= '0;
      pendWb     <= 1'b0;
      pendRd     <= '0;
      pendResult <= '0;
      wbValid    <= 1'b0;
      wbEn       <= 1'b0;
      wbRd       <= '0;
      wbResult   <= '0;
      memErr     <= 1'b0;
    end else begin
      state      <= nextState;
      waitCnt    <= nextWaitCnt;
      memReq     <= nextMemReq;
      memWe      <= nextMemWe;
      memAddr    <= nextMemAddr;
      memWdata   <= nextMemWdata;
      pendWb     <= nextPendWb;
      pendRd     <= nextPendRd;
      pendResult <= nextPendResult;
      wbValid    <= nextWbValid;
      wbEn       <= nextWbEn;
      wbRd       <= nextWbRd;
      wbResult   <= nextWbResult;
      memErr     <= nextMemErr;
    end
  end

  always_comb begin
    nextState      = state;
    nextWaitCnt    = waitCnt;
    nextMemReq     = memReq;
    nextMemWe      = memWe;
    nextMemAddr    = memAddr;
    nextMemWdata   = memWdata;
    nextPendWb     = pendWb;
    nextPendRd     = pendRd;
    nextPendResult = pendResult;
    nextWbValid    = 1'b0;
    nextWbEn       = 1'b0;
    nextWbRd       = wbRd;
    nextWbResult   = wbResult;
    nextMemErr     = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!isMem) begin
            nextWbValid  = 1'b1;
            nextWbEn     = isWb;
            nextWbRd     = rd;
            nextWbResult = isCall ? (pc + 32'd4) : aluResult;
          end else if (misaligned) begin
            // Faulting address goes out on wb_result for debug visibility.
            nextWbValid  = 1'b1;
            nextMemErr   = 1'b1;
            nextWbRd     = rd;
            nextWbResult = aluResult;
          end else begin
            nextState      = ACCESS;
            nextWaitCnt    = '0;
            nextMemReq     = 1'b1;
            nextMemWe      = isSt & ~isLd;
            nextMemAddr    = aluResult[ADDR_W-1:0];
            nextMemWdata   = op2;
            nextPendWb     = isWb;
            nextPendRd     = rd;
            nextPendResult = aluResult;
          end
        end
      end

      ACCESS: begin
        if (mem_ack) begin
          nextState    = IDLE;
          nextMemReq   = 1'b0;
          nextWbValid  = 1'b1;
          nextWbRd     = pendRd;
          nextWbEn     = memWe ? 1'b0 : pendWb;
          nextWbResult = memWe ? pendResult : mem_rdata;
        end else if (waitCnt == CNT_LAST) begin
          nextState    = IDLE;
          nextMemReq   = 1'b0;
          nextWbValid  = 1'b1;
          nextMemErr   = 1'b1;
          nextWbRd     = pendRd;
          nextWbResult = pendResult;
        end else begin
          nextWaitCnt = waitCnt + 1'b1;
        end
      end

      default: nextState = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign mem_req   = memReq;
  assign mem_we    = memWe;
  assign mem_addr  = memAddr;
  assign mem_wdata = memWdata;
  assign wb_valid  = wbValid;
  assign wb_en     = wbEn;
  assign wb_rd     = wbRd;
  assign wb_result = wbResult;
  assign mem_err   = memErr;

endmodule

// File: doc/ma_stage.md
# ma_stage

Memory-access stage of the RV32-style pipeline, directly downstream of the execute stage. Captures the execute result, store operand and control bits. Load/store instructions drive a request/acknowledge handshake to data memory. Holds the upstream pipeline while an access is pending, then presents a registered writeback bundle (result, destination register, write enable) to the writeback stage.

## Interface
- TIMEOUT, 16: max cycles the stage waits for mem_ack before aborting (≥2).
- ADDR_W, 32: data-memory address width.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  execute stage presents an instruction this cycle.
- in_ready  out  1  stage can accept; combinational, high only in IDLE.
- pc  in  32  PC of the incoming instruction.
- aluResult  in  32  execute result; effective address for isLd/isSt.
- op2  in  32  store data.
- rd  in  5  destination register index.
- isLd, isSt, isWb, isCall  in  1 each  control bits from decode.
- mem_req  out  1  memory request, held until acknowledged or aborted.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req.
- mem_addr  out  ADDR_W  word address (aluResult[ADDR_W-1:0]); stable while mem_req.
- mem_wdata  out  32  store data; stable while mem_req.
- mem_ack  in  1  memory completes the access this cycle.
- mem_rdata  in  32  load data, valid with mem_ack.
- wb_valid  out  1  one-cycle pulse: writeback bundle valid.
- wb_en  out  1  register-file write enable, qualified by wb_valid.
- wb_rd  out  5  destination register.
- wb_result  out  32  value to write.
- mem_err  out  1  one-cycle pulse with wb_valid on misalign or timeout.

## Operation
- States: IDLE, ACCESS.
- IDLE, in_valid=1, neither isLd nor isSt: capture bundle; next edge wb_valid=1 and wb_result = isCall ? pc+4 : aluResult (mod 2^32). Set wb_en=isWb. Stay IDLE.
- IDLE, in_valid=1, isLd or isSt, aluResult[1:0]≠0: no request. Next edge wb_valid=1, wb_en=0, mem_err=1.
- IDLE, in_valid=1, isLd or isSt, aligned: latch address, data and control. Go to ACCESS with mem_req=1 from the next cycle. Clear the wait counter.
- If isLd and isSt are both set, treat as a load.
- ACCESS: mem_req, mem_we, mem_addr and mem_wdata held constant. The wait counter increments each cycle.
- ACCESS, mem_ack=1: drop mem_req at the next edge and return to IDLE. At the same edge assert wb_valid.
  - Load: wb_result=mem_rdata, wb_en=isWb.
  - Store: wb_result=aluResult, wb_en=0.
- ACCESS, no ack and counter = TIMEOUT-1: abort. Drop mem_req, return to IDLE, and pulse wb_valid with wb_en=0 and mem_err=1.
- mem_ack on the timeout cycle counts as success; ack wins over abort.
- mem_ack while in IDLE is ignored.
- wb_en is never 1 when mem_err is 1.
- in_valid is ignored while in_ready=0; upstream must hold its bundle.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_en=0, wb_rd=0, wb_result=0, mem_err=0, counter=0. Reset asserted in ACCESS aborts the access with no writeback pulse.
- Non-memory latency: accepted at edge N, wb_valid high during cycle N+1.
- Memory latency:
  - Accepted at edge N; mem_req high from cycle N+1.
  - Ack sampled at edge M; wb_valid high during cycle M+1 and mem_req low.
  - Zero-wait memory (ack in first req cycle) gives 2-cycle latency.
- in_ready is low from cycle N+1 until the cycle after ack or abort. Back-to-back non-memory instructions sustain one per cycle.
- The wb bundle holds its value between pulses; only wb_valid, wb_en and mem_err deassert.

## Test plan
- Reset with in_valid=1: all outputs 0, in_ready=1. First instruction is accepted only after reset deasserts.
- Three back-to-back non-memory ops (aluResult 5, 7, 9; isWb=1) → wb_valid on three consecutive cycles with wb_result 5, 7, 9. isCall op with pc=0x100 → wb_result=0x104.
- Load from 0x40, memory acks after 3 cycles with rdata=0xDEADBEEF:
  - mem_req held exactly 3 cycles with mem_addr=0x40, mem_we=0.
  - in_ready low throughout.
  - Then wb_valid, wb_en=1, wb_result=0xDEADBEEF.
- Store to 0x44 with op2=0x1234, ack in first req cycle → mem_we=1, mem_wdata=0x1234, wb_valid with wb_en=0, total latency 2 cycles.
- Load to 0x42 → no mem_req; next cycle wb_valid=1, mem_err=1, wb_en=0. Load with no ack, TIMEOUT=4 → mem_req for 4 cycles, then mem_err pulse, state IDLE.
- Ack arriving exactly on the TIMEOUT-1 cycle → success writeback, mem_err=0. Reset asserted mid-ACCESS → mem_req drops next edge and no wb_valid pulse occurs.
